// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with a
// hardware return stack for CALL/RET and a sticky error halt.
module multicycle_control_unit #(
   parameter int PC_W        = 16,
   parameter int REG_AW      = 5,
   parameter int STACK_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        imem_req,
   output logic [PC_W-1:0]             imem_addr,
   input  logic                        imem_valid,
   input  logic [63:0]                 imem_data,
   output logic                        reg_read_enable,
   output logic [REG_AW-1:0]           read_reg1_addr,
   output logic [REG_AW-1:0]           read_reg2_addr,
   output logic                        alu_enable,
   output logic [5:0]                  alu_op,
   output logic                        alu_imm_sel,
   output logic [15:0]                 immediate,
   input  logic                        alu_sign,
   input  logic                        alu_zero,
   input  logic                        alu_overflow,
   output logic                        dmem_read,
   output logic                        dmem_write,
   output logic [15:0]                 dmem_addr,
   input  logic                        dmem_ready,
   output logic                        reg_write_enable,
   output logic [REG_AW-1:0]           write_reg_addr,
   output logic                        wb_sel,
   output logic [2:0]                  flags,
   output logic [PC_W-1:0]             pc,
   output logic [$clog2(STACK_DEPTH):0] stack_count,
   output logic                        halted,
   output logic [1:0]                  error_code
);
   localparam int SW = $clog2(STACK_DEPTH);
   localparam int CW = SW + 1;

   localparam logic [5:0] T_ALU_R = 6'd0;
   localparam logic [5:0] T_ALU_I = 6'd1;
   localparam logic [5:0] T_MEM   = 6'd2;
   localparam logic [5:0] T_BR    = 6'd4;
   localparam logic [5:0] T_CMP   = 6'd5;
   localparam logic [5:0] T_NOP   = 6'd6;

   localparam logic [5:0] OP_LOAD  = 6'd1;
   localparam logic [5:0] OP_STORE = 6'd2;
   localparam logic [5:0] OP_JMP   = 6'd1;
   localparam logic [5:0] OP_CALL  = 6'd2;
   localparam logic [5:0] OP_RET   = 6'd3;
   localparam logic [5:0] OP_JZ    = 6'd4;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_OVER    = 2'b10;
   localparam logic [1:0] ERR_UNDER   = 2'b11;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t            state_reg, state_next;
   logic [63:0]       ir_reg, ir_next;
   logic [PC_W-1:0]   pc_reg, pc_next;
   logic [2:0]        flags_reg, flags_next;
   logic [CW-1:0]     count_reg, count_next;
   logic [1:0]        err_reg, err_next;
   logic              push_en;

   logic [PC_W-1:0]   stack_mem [STACK_DEPTH];

   logic [5:0]        ir_type, ir_op;
   logic [15:0]       ir_imm;
   logic [REG_AW-1:0] ir_rd;
   logic [PC_W-1:0]   pc_inc, imm_pc;
   logic [SW-1:0]     push_idx, pop_idx;
   logic              unused_ir_bits;

   assign ir_type  = ir_reg[63:58];
   assign ir_op    = ir_reg[57:52];
   assign ir_rd    = ir_reg[47 +: REG_AW];
   assign ir_imm   = ir_reg[15:0];
   assign pc_inc   = pc_reg + PC_W'(1);
   assign imm_pc   = PC_W'(ir_imm);
   assign push_idx = SW'(count_reg);
   assign pop_idx  = SW'(count_reg - CW'(1));
   assign unused_ir_bits = ^ir_reg[36:16];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_FETCH;
         ir_reg    <= '0;
         pc_reg    <= '0;
         flags_reg <= '0;
         count_reg <= '0;
         err_reg   <= ERR_NONE;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
         pc_reg    <= pc_next;
         flags_reg <= flags_next;
         count_reg <= count_next;
         err_reg   <= err_next;
      end
   end

   // Return-stack storage carries no reset; only entries below count_reg are meaningful.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[push_idx] <= pc_inc;
      end
   end

   always_comb begin
      state_next = state_reg;
      ir_next    = ir_reg;
      pc_next    = pc_reg;
      flags_next = flags_reg;
      count_next = count_reg;
      err_next   = err_reg;
      push_en    = 1'b0;
      case (state_reg)
         S_FETCH: begin
            if (imem_valid) begin
               ir_next    = imem_data;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            state_next = S_FETCH;
            case (ir_type)
               T_ALU_R, T_ALU_I, T_CMP: state_next = S_EXEC;
               T_MEM: begin
                  if (ir_op == OP_LOAD || ir_op == OP_STORE) begin
                     state_next = S_MEM;
                  end else begin
                     state_next = S_HALT;
                     err_next   = ERR_ILLEGAL;
                  end
               end
               T_BR: begin
                  case (ir_op)
                     OP_JMP: pc_next = imm_pc;
                     OP_CALL: begin
                        if (count_reg == CW'(STACK_DEPTH)) begin
                           state_next = S_HALT;
                           err_next   = ERR_OVER;
                        end else begin
                           push_en    = 1'b1;
                           count_next = count_reg + CW'(1);
                           pc_next    = imm_pc;
                        end
                     end
                     OP_RET: begin
                        if (count_reg == '0) begin
                           state_next = S_HALT;
                           err_next   = ERR_UNDER;
                        end else begin
                           count_next = count_reg - CW'(1);
                           pc_next    = stack_mem[pop_idx];
                        end
                     end
                     OP_JZ: pc_next = flags_reg[1] ? imm_pc : pc_inc;
                     default: begin
                        state_next = S_HALT;
                        err_next   = ERR_ILLEGAL;
                     end
                  endcase
               end
               T_NOP: pc_next = pc_inc;
               default: begin
                  state_next = S_HALT;
                  err_next   = ERR_ILLEGAL;
               end
            endcase
         end
         S_EXEC: begin
            if (ir_type == T_CMP) begin
               flags_next = {alu_sign, alu_zero, alu_overflow};
               pc_next    = pc_inc;
               state_next = S_FETCH;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (ir_op == OP_LOAD) begin
                  state_next = S_WB;
               end else begin
                  pc_next    = pc_inc;
                  state_next = S_FETCH;
               end
            end
         end
         S_WB: begin
            pc_next    = pc_inc;
            state_next = S_FETCH;
         end
         S_HALT: state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   // Strobes are forced low while reset is asserted, even though state already reads FETCH.
   always_comb begin
      imem_req         = 1'b0;
      reg_read_enable  = 1'b0;
      alu_enable       = 1'b0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      reg_write_enable = 1'b0;
      wb_sel           = 1'b0;
      if (!reset) begin
         case (state_reg)
            S_FETCH:  imem_req = 1'b1;
            S_DECODE: reg_read_enable = 1'b1;
            S_EXEC:   alu_enable = 1'b1;
            S_MEM: begin
               dmem_read  = (ir_op == OP_LOAD);
               dmem_write = (ir_op == OP_STORE);
            end
            S_WB: begin
               reg_write_enable = (ir_rd != '0);
               wb_sel           = (ir_type == T_MEM);
            end
            default: ;
         endcase
      end
   end

   assign imem_addr      = pc_reg;
   assign pc             = pc_reg;
   assign read_reg1_addr = ir_reg[42 +: REG_AW];
   assign read_reg2_addr = ir_reg[37 +: REG_AW];
   assign write_reg_addr = ir_rd;
   assign alu_op         = ir_op;
   assign alu_imm_sel    = (ir_type == T_ALU_I);
   assign immediate      = ir_imm;
   assign dmem_addr      = ir_imm;
   assign flags          = flags_reg;
   assign stack_count    = count_reg;
   assign halted         = (state_reg == S_HALT);
   assign error_code     = err_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed table, hand-written corner
// sequences, and random instruction streams against an instruction-level model.
`timescale 1ns/1ps
module tb_multicycle_control_unit;
   localparam int PC_W   = 16;
   localparam int REG_AW = 5;
   localparam int DEPTH  = 8;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_valid = 1'b0;
   logic [63:0]       imem_data = '0;
   logic              reg_read_enable;
   logic [REG_AW-1:0] read_reg1_addr, read_reg2_addr, write_reg_addr;
   logic              alu_enable, alu_imm_sel;
   logic [5:0]        alu_op;
   logic [15:0]       immediate, dmem_addr;
   logic              alu_sign = 1'b0, alu_zero = 1'b0, alu_overflow = 1'b0;
   logic              dmem_read, dmem_write;
   logic              dmem_ready = 1'b0;
   logic              reg_write_enable, wb_sel, halted;
   logic [2:0]        flags;
   logic [PC_W-1:0]   pc;
   logic [CW-1:0]     stack_count;
   logic [1:0]        error_code;

   multicycle_control_unit #(.PC_W(PC_W), .REG_AW(REG_AW), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
      .reg_read_enable(reg_read_enable), .read_reg1_addr(read_reg1_addr), .read_reg2_addr(read_reg2_addr),
      .alu_enable(alu_enable), .alu_op(alu_op), .alu_imm_sel(alu_imm_sel), .immediate(immediate),
      .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_ready(dmem_ready),
      .reg_write_enable(reg_write_enable), .write_reg_addr(write_reg_addr), .wb_sel(wb_sel),
      .flags(flags), .pc(pc), .stack_count(stack_count), .halted(halted), .error_code(error_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mk(input logic [5:0] t, input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] imm);
      logic [63:0] w;
      w = '0;
      w[63:58] = t;
      w[57:52] = op;
      w[51:47] = rd;
      w[46:42] = rs1;
      w[41:37] = rs2;
      w[36:16] = 21'($urandom);
      w[15:0]  = imm;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observations gathered while one instruction runs
   int o_lat, o_timeout, o_stall_bad, o_rd_en, o_rs1, o_rs2, o_imm;
   int o_alu_cnt, o_alu_cyc, o_alu_imm, o_alu_op;
   int o_drd, o_dwr, o_daddr, o_daddr_moved;
   int o_wr_cnt, o_wr_cyc, o_wr_addr, o_wb_sel, o_halt_strobes;

   task automatic run_instr(input logic [63:0] ins, input int iw, input int dw, input logic [2:0] af);
      int guard;
      int n;
      int mcnt;
      int fetch_pc;
      o_lat = 0; o_timeout = 0; o_stall_bad = 0; o_rd_en = 0; o_rs1 = -1; o_rs2 = -1; o_imm = -1;
      o_alu_cnt = 0; o_alu_cyc = 0; o_alu_imm = -1; o_alu_op = -1;
      o_drd = 0; o_dwr = 0; o_daddr = -1; o_daddr_moved = 0;
      o_wr_cnt = 0; o_wr_cyc = 0; o_wr_addr = -1; o_wb_sel = -1; o_halt_strobes = 0;
      {alu_sign, alu_zero, alu_overflow} = af;
      imem_valid = 1'b0;
      dmem_ready = 1'b0;
      guard = 0;
      while (!imem_req && guard < 20) begin
         step();
         guard++;
      end
      if (!imem_req) begin
         o_timeout = 1;
         return;
      end
      fetch_pc = int'(imem_addr);
      for (int k = 0; k < iw; k++) begin
         step();
         if (!imem_req || int'(imem_addr) != fetch_pc) o_stall_bad = 1;
      end
      imem_valid = 1'b1;
      imem_data  = ins;
      n = 0;
      mcnt = 0;
      while (n < 50) begin
         step();
         n++;
         imem_valid = 1'b0;
         dmem_ready = 1'b0;
         if (imem_req || halted) break;
         if (reg_read_enable) begin
            o_rd_en++;
            o_rs1 = int'(read_reg1_addr);
            o_rs2 = int'(read_reg2_addr);
            o_imm = int'(immediate);
         end
         if (alu_enable) begin
            o_alu_cnt++;
            o_alu_cyc = n + 1;
            o_alu_imm = int'(alu_imm_sel);
            o_alu_op  = int'(alu_op);
         end
         if (dmem_read || dmem_write) begin
            if (dmem_read) o_drd++;
            if (dmem_write) o_dwr++;
            if (o_daddr < 0) o_daddr = int'(dmem_addr);
            else if (int'(dmem_addr) != o_daddr) o_daddr_moved = 1;
            dmem_ready = (mcnt >= dw);
            mcnt++;
         end
         if (reg_write_enable) begin
            o_wr_cnt++;
            o_wr_cyc  = n + 1;
            o_wr_addr = int'(write_reg_addr);
            o_wb_sel  = int'(wb_sel);
         end
      end
      o_lat = n;
      if (n >= 50) o_timeout = 1;
      if (halted)
         o_halt_strobes = int'({imem_req, reg_read_enable, alu_enable, dmem_read, dmem_write, reg_write_enable, wb_sel});
      dmem_ready = 1'b0;
   endtask

   // Instruction-level reference model
   int       m_pc, m_err, m_halted;
   logic [2:0] m_flags;
   int       m_stack[$];
   int e_lat, e_alu, e_wr, e_wbsel, e_drd, e_dwr, e_imm_sel;

   task automatic model_reset();
      m_pc = 0; m_err = 0; m_halted = 0; m_flags = 3'b000;
      m_stack.delete();
   endtask

   task automatic model_exec(input logic [63:0] ins, input int dw, input logic [2:0] af);
      int ty, op, rd, imm, nxt;
      ty  = int'(ins[63:58]);
      op  = int'(ins[57:52]);
      rd  = int'(ins[51:47]);
      imm = int'(ins[15:0]);
      nxt = (m_pc + 1) % 65536;
      e_lat = 2; e_alu = 0; e_wr = 0; e_wbsel = 0; e_drd = 0; e_dwr = 0;
      e_imm_sel = (ty == 1) ? 1 : 0;
      if (ty == 0 || ty == 1) begin
         e_lat = 4; e_alu = 1; e_wr = (rd != 0); m_pc = nxt;
      end else if (ty == 5) begin
         e_lat = 3; e_alu = 1; m_flags = af; m_pc = nxt;
      end else if (ty == 2 && op == 1) begin
         e_lat = 4 + dw; e_drd = dw + 1; e_wr = (rd != 0); e_wbsel = 1; m_pc = nxt;
      end else if (ty == 2 && op == 2) begin
         e_lat = 3 + dw; e_dwr = dw + 1; m_pc = nxt;
      end else if (ty == 6) begin
         m_pc = nxt;
      end else if (ty == 4 && op == 1) begin
         m_pc = imm;
      end else if (ty == 4 && op == 2) begin
         if (m_stack.size() == DEPTH) m_err = 2;
         else begin
            m_stack.push_back(nxt);
            m_pc = imm;
         end
      end else if (ty == 4 && op == 3) begin
         if (m_stack.size() == 0) m_err = 3;
         else m_pc = m_stack.pop_back();
      end else if (ty == 4 && op == 4) begin
         m_pc = m_flags[1] ? imm : nxt;
      end else begin
         m_err = 1;
      end
      if (m_err != 0) m_halted = 1;
   endtask

   task automatic check_vs_model(input logic [63:0] ins);
      chk("timeout", o_timeout, 0);
      chk("imem_stall", o_stall_bad, 0);
      chk("latency", o_lat, e_lat);
      chk("pc", pc, m_pc);
      chk("flags", flags, m_flags);
      chk("stack_count", stack_count, m_stack.size());
      chk("error_code", error_code, m_err);
      chk("halted", halted, m_halted);
      chk("reg_read_cycles", o_rd_en, 1);
      chk("rs1", o_rs1, ins[46:42]);
      chk("rs2", o_rs2, ins[41:37]);
      chk("immediate", o_imm, ins[15:0]);
      chk("alu_cycles", o_alu_cnt, e_alu);
      if (e_alu != 0) begin
         chk("alu_imm_sel", o_alu_imm, e_imm_sel);
         chk("alu_op", o_alu_op, ins[57:52]);
      end
      chk("reg_write_cycles", o_wr_cnt, e_wr);
      if (e_wr != 0) begin
         chk("write_reg_addr", o_wr_addr, ins[51:47]);
         chk("wb_sel", o_wb_sel, e_wbsel);
      end
      chk("dmem_read_cycles", o_drd, e_drd);
      chk("dmem_write_cycles", o_dwr, e_dwr);
      if (e_drd + e_dwr > 0) begin
         chk("dmem_addr", o_daddr, ins[15:0]);
         chk("dmem_addr_stable", o_daddr_moved, 0);
      end
      if (m_halted != 0) chk("halt_strobes", o_halt_strobes, 0);
      else chk("imem_addr", imem_addr, m_pc);
   endtask

   task automatic do_reset();
      imem_valid = 1'b0;
      dmem_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst_pc", pc, 0);
      chk("rst_strobes", {imem_req, reg_read_enable, alu_enable, dmem_read, dmem_write, reg_write_enable, wb_sel}, 0);
      chk("rst_status", {halted, error_code, stack_count, flags}, 0);
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rel_imem_req", imem_req, 1);
      chk("rel_imem_addr", imem_addr, 0);
      model_reset();
   endtask

   typedef struct {
      logic [63:0] instr;
      int          dw;
      logic [2:0]  af;
      int          lat;
      int          pc;
      int          cnt;
      int          fl;
      int          wr;
      int          drd;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, iw, dw;
      logic [5:0] ty, op;
      logic [4:0] rd;
      logic [15:0] imm;
      logic [2:0] af;
      logic [63:0] ins;

      tbl[0]  = '{mk(6'd0, 6'd5, 5'd3, 5'd1, 5'd2, 16'h0000), 0, 3'b000, 4, 16'h0001, 0, 3'b000, 1, 0};
      tbl[1]  = '{mk(6'd1, 6'd2, 5'd0, 5'd4, 5'd5, 16'h1234), 0, 3'b000, 4, 16'h0002, 0, 3'b000, 0, 0};
      tbl[2]  = '{mk(6'd5, 6'd7, 5'd0, 5'd1, 5'd1, 16'h0000), 0, 3'b010, 3, 16'h0003, 0, 3'b010, 0, 0};
      tbl[3]  = '{mk(6'd4, 6'd4, 5'd0, 5'd0, 5'd0, 16'h0020), 0, 3'b000, 2, 16'h0020, 0, 3'b010, 0, 0};
      tbl[4]  = '{mk(6'd5, 6'd7, 5'd0, 5'd1, 5'd1, 16'h0000), 0, 3'b101, 3, 16'h0021, 0, 3'b101, 0, 0};
      tbl[5]  = '{mk(6'd4, 6'd4, 5'd0, 5'd0, 5'd0, 16'h0040), 0, 3'b000, 2, 16'h0022, 0, 3'b101, 0, 0};
      tbl[6]  = '{mk(6'd2, 6'd2, 5'd0, 5'd6, 5'd0, 16'h0010), 0, 3'b000, 3, 16'h0023, 0, 3'b101, 0, 0};
      tbl[7]  = '{mk(6'd2, 6'd1, 5'd7, 5'd6, 5'd0, 16'h0040), 3, 3'b000, 7, 16'h0024, 0, 3'b101, 1, 4};
      tbl[8]  = '{mk(6'd4, 6'd1, 5'd0, 5'd0, 5'd0, 16'h0005), 0, 3'b000, 2, 16'h0005, 0, 3'b101, 0, 0};
      tbl[9]  = '{mk(6'd4, 6'd2, 5'd0, 5'd0, 5'd0, 16'h0100), 0, 3'b000, 2, 16'h0100, 1, 3'b101, 0, 0};
      tbl[10] = '{mk(6'd4, 6'd3, 5'd0, 5'd0, 5'd0, 16'h0000), 0, 3'b000, 2, 16'h0006, 0, 3'b101, 0, 0};
      tbl[11] = '{mk(6'd4, 6'd1, 5'd0, 5'd0, 5'd0, 16'hFFFF), 0, 3'b000, 2, 16'hFFFF, 0, 3'b101, 0, 0};
      tbl[12] = '{mk(6'd6, 6'd9, 5'd0, 5'd0, 5'd0, 16'h0000), 0, 3'b000, 2, 16'h0000, 0, 3'b101, 0, 0};
      tbl[13] = '{mk(6'd2, 6'd2, 5'd0, 5'd3, 5'd0, 16'h0080), 2, 3'b000, 5, 16'h0001, 0, 3'b101, 0, 0};

      // ALU-reg at pc 0: strobe timing per cycle
      do_reset();
      run_instr(mk(6'd0, 6'd3, 5'd3, 5'd1, 5'd2, 16'h0000), 0, 0, 3'b000);
      chk("req023_alu_cycle", o_alu_cyc, 3);
      chk("req023_alu_count", o_alu_cnt, 1);
      chk("req023_wr_cycle", o_wr_cyc, 4);
      chk("req023_wr_addr", o_wr_addr, 3);
      chk("req023_next_addr", imem_addr, 1);
      $display("txn seq_alu: lat=%0d pc=%h", o_lat, pc);

      // Directed program table
      do_reset();
      for (int i = 0; i < 14; i++) begin
         run_instr(tbl[i].instr, 0, tbl[i].dw, tbl[i].af);
         chk("tbl_timeout", o_timeout, 0);
         chk("tbl_latency", o_lat, tbl[i].lat);
         chk("tbl_pc", pc, tbl[i].pc);
         chk("tbl_stack_count", stack_count, tbl[i].cnt);
         chk("tbl_flags", flags, tbl[i].fl);
         chk("tbl_wr_cycles", o_wr_cnt, tbl[i].wr);
         chk("tbl_dmem_read_cycles", o_drd, tbl[i].drd);
         chk("tbl_error_code", error_code, 0);
         if (tbl[i].wr != 0) begin
            chk("tbl_wr_addr", o_wr_addr, tbl[i].instr[51:47]);
            chk("tbl_wb_sel", o_wb_sel, (tbl[i].drd > 0) ? 1 : 0);
         end
         if (tbl[i].drd > 0) begin
            chk("tbl_dmem_addr", o_daddr, tbl[i].instr[15:0]);
            chk("tbl_dmem_addr_stable", o_daddr_moved, 0);
         end
         $display("txn tbl %0d: instr=%h lat=%0d pc=%h cnt=%0d flags=%b", i, tbl[i].instr, o_lat, pc, stack_count, flags);
      end

      // Nested CALLs past the stack depth
      do_reset();
      for (int k = 0; k <= DEPTH; k++) begin
         run_instr(mk(6'd4, 6'd2, 5'd0, 5'd0, 5'd0, 16'(16'h0100 + k * 16)), 0, 0, 3'b000);
         if (k < DEPTH) begin
            chk("call_count", stack_count, k + 1);
            chk("call_pc", pc, 16'h0100 + k * 16);
         end
         $display("txn call %0d: pc=%h cnt=%0d halted=%0d err=%0d", k, pc, stack_count, halted, error_code);
      end
      chk("overflow_halted", halted, 1);
      chk("overflow_err", error_code, 2);
      chk("overflow_count", stack_count, DEPTH);
      chk("overflow_pc", pc, 16'h0100 + (DEPTH - 1) * 16);
      imem_valid = 1'b1;
      step();
      step();
      step();
      imem_valid = 1'b0;
      chk("halt_sticky", halted, 1);
      chk("halt_no_fetch", imem_req, 0);
      chk("halt_err_held", error_code, 2);

      // Illegal type on fresh reset
      do_reset();
      run_instr(mk(6'h3F, 6'd0, 5'd1, 5'd0, 5'd0, 16'h0000), 0, 0, 3'b000);
      chk("illegal_err", error_code, 1);
      chk("illegal_halted", halted, 1);
      chk("illegal_pc", pc, 0);
      $display("txn illegal: err=%0d halted=%0d", error_code, halted);

      // RET on empty stack
      do_reset();
      run_instr(mk(6'd4, 6'd3, 5'd0, 5'd0, 5'd0, 16'h0000), 0, 0, 3'b000);
      chk("underflow_err", error_code, 3);
      chk("underflow_halted", halted, 1);
      $display("txn underflow: err=%0d halted=%0d", error_code, halted);

      // Reset in the middle of a MEM handshake
      do_reset();
      run_instr(mk(6'd4, 6'd1, 5'd0, 5'd0, 5'd0, 16'h0030), 0, 0, 3'b000);
      chk("pre_mem_pc", pc, 16'h0030);
      imem_valid = 1'b1;
      imem_data  = mk(6'd2, 6'd1, 5'd4, 5'd0, 5'd0, 16'h0040);
      step();
      imem_valid = 1'b0;
      step();
      chk("mid_mem_read", dmem_read, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_mem_abandon", dmem_read, 0);
      chk("mid_mem_pc", pc, 0);
      step();
      reset = 1'b0;
      #1;
      chk("mid_mem_rel_req", imem_req, 1);
      chk("mid_mem_rel_addr", imem_addr, 0);
      $display("txn mem_reset: pc=%h", pc);

      // Reset while FETCH is stalled
      model_reset();
      run_instr(mk(6'd4, 6'd1, 5'd0, 5'd0, 5'd0, 16'h0033), 0, 0, 3'b000);
      step();
      step();
      chk("stalled_fetch_addr", imem_addr, 16'h0033);
      #2 reset = 1'b1;
      #1;
      chk("mid_fetch_pc", pc, 0);
      chk("mid_fetch_req", imem_req, 0);
      step();
      reset = 1'b0;
      #1;
      chk("mid_fetch_rel_addr", imem_addr, 0);
      run_instr(mk(6'd6, 6'd0, 5'd0, 5'd0, 5'd0, 16'h0000), 0, 0, 3'b000);
      chk("post_reset_nop_pc", pc, 1);
      $display("txn fetch_reset: pc=%h", pc);

      // Random streams against the reference model
      do_reset();
      for (int t = 0; t < 250; t++) begin
         r   = $urandom_range(0, 99);
         rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         op  = 6'($urandom);
         imm = 16'($urandom);
         af  = 3'($urandom);
         iw  = $urandom_range(0, 2);
         dw  = $urandom_range(0, 2);
         if (r < 18) ty = 6'd0;
         else if (r < 30) ty = 6'd1;
         else if (r < 42) ty = 6'd5;
         else if (r < 52) begin ty = 6'd2; op = 6'd1; end
         else if (r < 60) begin ty = 6'd2; op = 6'd2; end
         else if (r < 66) ty = 6'd6;
         else if (r < 93) begin ty = 6'd4; op = 6'($urandom_range(1, 4)); end
         else begin
            case ($urandom_range(0, 3))
               0: ty = 6'd3;
               1: ty = 6'($urandom_range(7, 63));
               2: begin ty = 6'd2; op = 6'($urandom_range(3, 63)); end
               default: begin ty = 6'd4; op = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(5, 63)); end
            endcase
         end
         ins = mk(ty, op, rd, 5'($urandom), 5'($urandom), imm);
         run_instr(ins, iw, dw, af);
         model_exec(ins, dw, af);
         check_vs_model(ins);
         $display("txn rnd %0d: instr=%h lat=%0d pc=%h cnt=%0d err=%0d", t, ins, o_lat, pc, stack_count, error_code);
         if (m_halted != 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  PC_W  16  program-counter and instruction-address width
  REG_AW  5  register-file address width
  STACK_DEPTH  8  return-stack entries (power of two, >=2)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  imem_req  out  1  instruction fetch request
  imem_addr  out  PC_W  fetch address (=pc)
  imem_valid  in  1  imem_data valid this cycle
  imem_data  in  64  fetched instruction
  reg_read_enable  out  1  register-file read strobe
  read_reg1_addr  out  REG_AW  rs1
  read_reg2_addr  out  REG_AW  rs2
  alu_enable  out  1  ALU execute strobe
  alu_op  out  6  ALU operation (=opcode)
  alu_imm_sel  out  1  1: ALU operand 2 is immediate
  immediate  out  16  instruction bits [15:0]
  alu_sign, alu_zero, alu_overflow  in  1 each  ALU result flags
  dmem_read  out  1  load request
  dmem_write  out  1  store request
  dmem_addr  out  16  data address (=immediate)
  dmem_ready  in  1  data access complete
  reg_write_enable  out  1  register write strobe
  write_reg_addr  out  REG_AW  rd
  wb_sel  out  1  0: ALU result, 1: memory data
  flags  out  3  {sign, zero, overflow}
  pc  out  PC_W  current program counter
  stack_count  out  clog2(STACK_DEPTH)+1  occupied return-stack entries
  halted  out  1  sticky halt
  error_code  out  2  00 none, 01 illegal, 10 stack overflow, 11 stack underflow
REQ-003 Instruction fields SHALL be: type[63:58], opcode[57:52], rd[51:47], rs1[46:42], rs2[41:37], imm[15:0]; register fields use the low REG_AW bits.

Function
REQ-004 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; all strobes are Moore outputs of the state.
REQ-005 FETCH: imem_req=1; on imem_valid latch imem_data into the instruction register and go to DECODE; otherwise hold, with no timeout.
REQ-006 DECODE: reg_read_enable=1 for one cycle; dispatch on type as in REQ-007..012.
REQ-007 Type 000000 (ALU reg) and 000001 (ALU imm) SHALL go to EXEC; alu_imm_sel = (type==000001).
REQ-008 Type 000101 (compare) SHALL go to EXEC; in EXEC latch {alu_sign, alu_zero, alu_overflow} into flags, pc+1, then FETCH; no register write.
REQ-009 Type 000010 SHALL go to MEM for opcode 000001 (load) or 000010 (store); any other opcode is illegal.
REQ-010 Type 000100 SHALL resolve in DECODE, then go to FETCH:
  - 000001 JMP: pc=imm[PC_W-1:0].
  - 000010 CALL: push pc+1, then pc=imm.
  - 000011 RET: pop into pc.
  - 000100 JZ: pc=imm if flags zero=1, else pc+1.
REQ-011 Type 000110 (NOP) SHALL set pc+1 and go to FETCH.
REQ-012 Any other type/opcode SHALL go to HALT with error_code=01.
REQ-013 EXEC for ALU types SHALL hold alu_enable=1 for exactly one cycle, then go to WB.
REQ-014 MEM SHALL hold dmem_read or dmem_write with a stable dmem_addr until dmem_ready; then a load goes to WB with wb_sel=1, and a store sets pc+1 and goes to FETCH.
REQ-015 WB SHALL last one cycle, with reg_write_enable=1 unless rd==0 (write suppressed); it sets pc+1 and goes to FETCH.
REQ-016 pc arithmetic SHALL be modulo 2^PC_W (pc all-ones +1 -> 0).
REQ-017 CALL with stack_count==STACK_DEPTH SHALL go to HALT, error_code=10, with pc and stack unchanged.
REQ-018 RET with stack_count==0 SHALL go to HALT, error_code=11.
REQ-019 HALT SHALL be absorbing: halted=1, all strobes 0, error_code held until reset.
REQ-020 The minimum latency per instruction SHALL be: jump/NOP 2 cycles, compare/store 3 cycles, ALU/load 4 cycles (zero-wait handshakes).

Reset
REQ-021 On reset assertion, with no clock required: state=FETCH, pc=0, instruction register=0, flags=000, stack_count=0, halted=0, error_code=00, and every strobe output=0.
REQ-022 Reset during a pending FETCH or MEM handshake SHALL abandon it; after release, the first cycle drives imem_req=1 with imem_addr=0.

Verification
REQ-023 Reset, then ALU-reg at pc 0 with rd=3 and zero-wait memory -> alu_enable in cycle 3, reg_write_enable with write_reg_addr=3 in cycle 4, then imem_addr=1.
REQ-024 Load with imm=0x0040 and dmem_ready delayed 3 cycles -> dmem_read=1 and dmem_addr=0x0040 for 4 cycles, then WB with wb_sel=1.
REQ-025 CALL 0x0100 at pc 5, then RET -> stack_count 1 then 0, pc 0x0100 then 6.
REQ-026 STACK_DEPTH+1 nested CALLs -> last CALL halts with error_code=10 and stack_count=STACK_DEPTH; type 111111 on fresh reset -> error_code=01.
REQ-027 Compare with alu_zero=1, then JZ 0x0020 -> pc=0x0020; with alu_zero=0 -> pc advances by 1; JMP 0xFFFF then NOP -> pc=0x0000.
